// File: rtl/dcache_pkg.sv
// Shared types and field widths for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int unsigned DC_WIDTH       = 32;
  localparam int unsigned DC_SET_BITS    = 3;
  localparam int unsigned DC_WORD_BITS   = 2;
  localparam int unsigned DC_OFFSET_BITS = 2;
  localparam int unsigned DC_TAG_BITS    = DC_WIDTH - DC_SET_BITS - DC_WORD_BITS - DC_OFFSET_BITS;
  localparam int unsigned DC_BYTE_BITS   = 8;

  localparam logic ATYPE_WORD = 1'b0;
  localparam logic ATYPE_BYTE = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone,
    StStore
  } dcache_state_t;

endpackage

// File: rtl/dcache_store.sv
// Data bank (async read, byte-enabled write) and tag/valid bank for the data cache.
module dcache_store
  import dcache_pkg::*;
#(
  parameter int unsigned WIDTH     = DC_WIDTH,
  parameter int unsigned SET_BITS  = DC_SET_BITS,
  parameter int unsigned WORD_BITS = DC_WORD_BITS,
  parameter int unsigned TAG_BITS  = DC_TAG_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SET_BITS-1:0]   index,
  input  logic [WORD_BITS-1:0]  word,
  output logic [WIDTH-1:0]      rdata,
  output logic [TAG_BITS-1:0]   tag_rd,
  output logic                  valid_rd,
  input  logic                  data_we,
  input  logic [WIDTH/8-1:0]    data_be,
  input  logic [WIDTH-1:0]      data_wdata,
  input  logic                  line_we,
  input  logic [TAG_BITS-1:0]   tag_wr
);

  localparam int unsigned Sets  = 1 << SET_BITS;
  localparam int unsigned Words = 1 << WORD_BITS;

  logic [WIDTH-1:0]          data_q [Sets*Words];
  logic [TAG_BITS-1:0]       tag_q  [Sets];
  logic [Sets-1:0]           valid_q;
  logic [SET_BITS+WORD_BITS-1:0] slot;

  assign slot = {index, word};

  always_ff @(posedge clk) begin
    if (data_we) begin
      for (int b = 0; b < WIDTH / 8; b++) begin
        if (data_be[b]) data_q[slot][DC_BYTE_BITS*b +: DC_BYTE_BITS] <=
            data_wdata[DC_BYTE_BITS*b +: DC_BYTE_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) tag_q[index] <= tag_wr;
  end

  // Only the valid bits reset; a line becomes valid only after its last fill beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (line_we) begin
      valid_q[index] <= 1'b1;
    end
  end

  assign rdata    = data_q[slot];
  assign tag_rd   = tag_q[index];
  assign valid_rd = valid_q[index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache with miss/store FSM.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module data_cache
  import dcache_pkg::*;
#(
  parameter int unsigned WIDTH     = DC_WIDTH,
  parameter int unsigned SET_BITS  = DC_SET_BITS,
  parameter int unsigned WORD_BITS = DC_WORD_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ReadM,
  input  logic             MemWriteM,
  input  logic             a_typeM,
  input  logic [WIDTH-1:0] AddrM,
  input  logic [WIDTH-1:0] WriteDataM,
  output logic [WIDTH-1:0] ReadDataM,
  output logic             StallM,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
);

  localparam int unsigned TagBits  = WIDTH - SET_BITS - WORD_BITS - DC_OFFSET_BITS;
  localparam int unsigned LineLsb  = WORD_BITS + DC_OFFSET_BITS;
  localparam logic [WORD_BITS-1:0] LastBeat = '1;

  dcache_state_t state_q, state_d;
  logic [WORD_BITS-1:0] beat_q, beat_d, beat_next;
  logic             req_q, req_d, we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;

  logic [SET_BITS-1:0]  addr_index;
  logic [WORD_BITS-1:0] addr_word, store_word;
  logic [TagBits-1:0]   addr_tag, tag_rd;
  logic [WIDTH-1:0]     line_base, rdata;
  logic                 valid_rd, hit, rd_en;
  logic                 data_we, line_we;
  logic [3:0]           data_be;
  logic [WIDTH-1:0]     data_wdata;
  logic [7:0]           load_byte;

  assign addr_word  = AddrM[LineLsb-1:DC_OFFSET_BITS];
  assign addr_index = AddrM[SET_BITS+LineLsb-1:LineLsb];
  assign addr_tag   = AddrM[WIDTH-1:WIDTH-TagBits];
  assign line_base  = {AddrM[WIDTH-1:LineLsb], {LineLsb{1'b0}}};
  assign beat_next  = beat_q + 1'b1;
  assign hit        = valid_rd && (tag_rd == addr_tag);

  dcache_store #(
    .WIDTH     (WIDTH),
    .SET_BITS  (SET_BITS),
    .WORD_BITS (WORD_BITS),
    .TAG_BITS  (TagBits)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .index      (addr_index),
    .word       (store_word),
    .rdata      (rdata),
    .tag_rd     (tag_rd),
    .valid_rd   (valid_rd),
    .data_we    (data_we),
    .data_be    (data_be),
    .data_wdata (data_wdata),
    .line_we    (line_we),
    .tag_wr     (addr_tag)
  );

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    StallM     = 1'b0;
    rd_en      = 1'b0;
    data_we    = 1'b0;
    data_be    = '0;
    data_wdata = '0;
    line_we    = 1'b0;
    store_word = addr_word;
    unique case (state_q)
      StIdle: begin
        // A simultaneous load and store is treated as a store.
        if (MemWriteM) begin
          StallM  = 1'b1;
          state_d = StStore;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = AddrM;
          if (a_typeM == ATYPE_BYTE) begin
            be_d    = 4'b0001 << AddrM[1:0];
            wdata_d = {4{WriteDataM[7:0]}};
          end else begin
            be_d    = 4'b1111;
            wdata_d = WriteDataM;
          end
        end else if (ReadM) begin
          if (hit) begin
            rd_en = 1'b1;
          end else begin
            StallM  = 1'b1;
            state_d = StFill;
            beat_d  = '0;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = line_base;
          end
        end
      end
      StFill: begin
        StallM     = 1'b1;
        store_word = beat_q;
        if (mem_ack) begin
          data_we    = 1'b1;
          data_be    = 4'b1111;
          data_wdata = mem_rdata;
          beat_d     = beat_next;
          if (beat_q == LastBeat) begin
            line_we = 1'b1;
            req_d   = 1'b0;
            state_d = StDone;
          end else begin
            addr_d = line_base | (WIDTH'(beat_next) << DC_OFFSET_BITS);
          end
        end
      end
      StDone: begin
        rd_en   = 1'b1;
        state_d = StIdle;
      end
      StStore: begin
        StallM = !mem_ack;
        if (mem_ack) begin
          // No allocate: only a line already present is updated.
          if (hit) begin
            data_we    = 1'b1;
            data_be    = be_q;
            data_wdata = wdata_q;
          end
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  assign load_byte = rdata[8*AddrM[1:0] +: 8];
  assign ReadDataM = !rd_en ? '0 :
                     (a_typeM == ATYPE_BYTE) ? {{(WIDTH-8){1'b0}}, load_byte} : rdata;

`ifdef DCACHE_STATS_EN
  logic        hit_inc, miss_inc;
  logic [31:0] hit_q, miss_q;

  assign hit_inc  = (state_q == StIdle) && ReadM && !MemWriteM && hit;
  assign miss_inc = (state_q == StIdle) && ReadM && !MemWriteM && !hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit_inc && (hit_q != 32'hFFFF_FFFF))   hit_q  <= hit_q + 32'd1;
      if (miss_inc && (miss_q != 32'hFFFF_FFFF)) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache against a 1-cycle-ack backing memory.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        ReadM, MemWriteM, a_typeM;
  logic [31:0] AddrM, WriteDataM, ReadDataM;
  logic        StallM;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [31:0] hit_count, miss_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];
  int          rd_beats = 0;
  int          wr_beats = 0;
  logic [31:0] rd_log [0:63];
  logic [31:0] last_waddr, last_wdata;
  logic [3:0]  last_be;
  logic        stray = 1'b0;

  data_cache dut (
    .clk        (clk),
    .rst        (rst),
    .ReadM      (ReadM),
    .MemWriteM  (MemWriteM),
    .a_typeM    (a_typeM),
    .AddrM      (AddrM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  assign mem_ack   = mem_req | stray;
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        wr_beats   <= wr_beats + 1;
        last_waddr <= mem_addr;
        last_wdata <= mem_wdata;
        last_be    <= mem_be;
      end else begin
        rd_log[rd_beats[5:0]] <= mem_addr;
        rd_beats <= rd_beats + 1;
      end
    end
  end

  // One M-stage access held until StallM drops; returns stall cycles and load data.
  task automatic do_access(input logic rd, input logic wr, input logic bt,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int stalls, output logic [31:0] rdata);
    @(negedge clk);
    ReadM = rd; MemWriteM = wr; a_typeM = bt; AddrM = a; WriteDataM = wd;
    stalls = 0;
    #1;
    while (StallM && stalls < 40) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (stalls >= 40) begin
      checks++; errors++;
      $display("FAIL access_timeout: addr %h still stalled after %0d cycles", a, stalls);
    end
    rdata = ReadDataM;
    @(posedge clk);
    #1;
    ReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ReadM = 0; MemWriteM = 0; a_typeM = 0; AddrM = 0; WriteDataM = 0;
    repeat (2) @(negedge clk);
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", StallM); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    checks++; if (mem_be !== 4'h0) begin errors++; $display("FAIL reset_be: got %h want 0", mem_be); end
    checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", ReadDataM); end
    checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", hit_count, miss_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill;
    int st; logic [31:0] d; int r0;
    r0 = rd_beats;
    do_access(1, 0, 0, 32'h40, 0, st, d);
    checks++; if (st !== 5) begin errors++; $display("FAIL fill_stall: got %0d want 5", st); end
    checks++; if (d !== 32'h11) begin errors++; $display("FAIL fill_data: got %h want 00000011", d); end
    checks++; if (rd_beats - r0 !== 4) begin errors++; $display("FAIL fill_beats: got %0d want 4", rd_beats - r0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_log[r0 + i] !== 32'h40 + 32'(4 * i)) begin
        errors++; $display("FAIL fill_addr%0d: got %h want %h", i, rd_log[r0 + i], 32'h40 + 32'(4 * i));
      end
    end
    do_access(1, 0, 0, 32'h44, 0, st, d);
    checks++; if (st !== 0) begin errors++; $display("FAIL hit_stall: got %0d want 0", st); end
    checks++; if (d !== 32'h22) begin errors++; $display("FAIL hit_data: got %h want 00000022", d); end
    checks++; if (rd_beats - r0 !== 4) begin errors++; $display("FAIL hit_no_req: beats %0d want 4", rd_beats - r0); end
`ifdef DCACHE_STATS_EN
    checks++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
      errors++; $display("FAIL stats_after_fill: got %0d/%0d want 1/1", hit_count, miss_count);
    end
`else
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      errors++; $display("FAIL stats_disabled: got %0d/%0d want 0/0", hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_byte_load;
    int st; logic [31:0] d; int r0;
    r0 = rd_beats;
    do_access(1, 0, 1, 32'h4B, 0, st, d);
    checks++; if (d !== 32'h0 || st !== 0) begin errors++; $display("FAIL byte_4b: got %h/%0d want 0/0", d, st); end
    do_access(1, 0, 1, 32'h48, 0, st, d);
    checks++; if (d !== 32'h33 || st !== 0) begin errors++; $display("FAIL byte_48: got %h/%0d want 33/0", d, st); end
    checks++; if (rd_beats !== r0) begin errors++; $display("FAIL byte_no_req: beats %0d want %0d", rd_beats, r0); end
  endtask

  task automatic test_byte_store;
    int st; logic [31:0] d; int w0, r0;
    w0 = wr_beats; r0 = rd_beats;
    do_access(0, 1, 1, 32'h45, 32'h1234_56A5, st, d);
    checks++; if (st !== 1) begin errors++; $display("FAIL bstore_stall: got %0d want 1", st); end
    checks++; if (wr_beats - w0 !== 1) begin errors++; $display("FAIL bstore_beats: got %0d want 1", wr_beats - w0); end
    checks++; if (last_be !== 4'b0010) begin errors++; $display("FAIL bstore_be: got %b want 0010", last_be); end
    checks++; if (last_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL bstore_wdata: got %h want a5a5a5a5", last_wdata); end
    checks++; if (last_waddr !== 32'h45) begin errors++; $display("FAIL bstore_addr: got %h want 00000045", last_waddr); end
    do_access(1, 0, 0, 32'h44, 0, st, d);
    checks++; if (d !== 32'h0000_A522 || st !== 0) begin
      errors++; $display("FAIL bstore_readback: got %h/%0d want 0000a522/0", d, st);
    end
    checks++; if (rd_beats !== r0) begin errors++; $display("FAIL bstore_no_fill: beats %0d want %0d", rd_beats, r0); end
  endtask

  task automatic test_store_miss;
    int st; logic [31:0] d; int w0, r0;
    w0 = wr_beats; r0 = rd_beats;
    do_access(0, 1, 0, 32'h100, 32'hDEAD_BEEF, st, d);
    checks++; if (wr_beats - w0 !== 1) begin errors++; $display("FAIL wstore_beats: got %0d want 1", wr_beats - w0); end
    checks++; if (rd_beats !== r0) begin errors++; $display("FAIL wstore_no_fill: beats %0d want %0d", rd_beats, r0); end
    checks++; if (last_be !== 4'hF || last_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wstore_bus: got %h/%h want f/deadbeef", last_be, last_wdata);
    end
    do_access(1, 0, 0, 32'h100, 0, st, d);
    checks++; if (st !== 5) begin errors++; $display("FAIL wstore_remiss: got %0d want 5", st); end
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wstore_load: got %h want deadbeef", d); end
    checks++; if (rd_log[r0] !== 32'h100) begin errors++; $display("FAIL wstore_fill_addr: got %h want 00000100", rd_log[r0]); end
  endtask

  task automatic test_store_priority;
    int st; logic [31:0] d; int w0, r0;
    w0 = wr_beats; r0 = rd_beats;
    do_access(1, 1, 0, 32'h44, 32'h5566_7788, st, d);
    checks++; if (wr_beats - w0 !== 1 || rd_beats !== r0) begin
      errors++; $display("FAIL both_req: wr %0d rd %0d want 1 0", wr_beats - w0, rd_beats - r0);
    end
    do_access(1, 0, 0, 32'h44, 0, st, d);
    checks++; if (d !== 32'h5566_7788 || st !== 0) begin
      errors++; $display("FAIL both_readback: got %h/%0d want 55667788/0", d, st);
    end
  endtask

  task automatic test_conflict;
    int st; logic [31:0] d;
    do_access(1, 0, 0, 32'h1C0, 0, st, d);
    checks++; if (st !== 5 || d !== 32'h8899_AABB) begin
      errors++; $display("FAIL conflict_fill: got %h/%0d want 8899aabb/5", d, st);
    end
    do_access(1, 0, 1, 32'h1C1, 0, st, d);
    checks++; if (d !== 32'hAA || st !== 0) begin errors++; $display("FAIL conflict_b1: got %h/%0d want aa/0", d, st); end
    do_access(1, 0, 1, 32'h1C3, 0, st, d);
    checks++; if (d !== 32'h88) begin errors++; $display("FAIL conflict_b3: got %h want 88", d); end
    do_access(1, 0, 0, 32'h1C4, 0, st, d);
    checks++; if (d !== 32'h0102_0304) begin errors++; $display("FAIL conflict_w1: got %h want 01020304", d); end
    do_access(1, 0, 0, 32'h40, 0, st, d);
    checks++; if (st !== 5 || d !== 32'h11) begin
      errors++; $display("FAIL conflict_evict: got %h/%0d want 00000011/5", d, st);
    end
  endtask

  task automatic test_stray_ack;
    int st; logic [31:0] d; int w0, r0;
    w0 = wr_beats; r0 = rd_beats;
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    checks++; if (mem_req !== 1'b0 || StallM !== 1'b0) begin
      errors++; $display("FAIL stray_ack: req %b stall %b want 0 0", mem_req, StallM);
    end
    do_access(1, 0, 0, 32'h44, 0, st, d);
    checks++; if (d !== 32'h5566_7788 || st !== 0 || rd_beats !== r0 || wr_beats !== w0) begin
      errors++; $display("FAIL stray_hit: got %h/%0d want 55667788/0", d, st);
    end
  endtask

  task automatic test_reset_mid_fill;
    int st; logic [31:0] d; int n;
    n = 0;
    @(negedge clk);
    ReadM = 1; MemWriteM = 0; a_typeM = 0; AddrM = 32'h80;
    while (!(mem_req && mem_addr == 32'h88) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 20) begin errors++; $display("FAIL midfill_wait: beat 2 not seen after %0d cycles", n); end
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL midfill_abort: req %b addr %h want 0 0", mem_req, mem_addr);
    end
    checks++; if (miss_count !== 32'h0 || hit_count !== 32'h0) begin
      errors++; $display("FAIL midfill_counts: got %0d/%0d want 0/0", hit_count, miss_count);
    end
    @(negedge clk);
    ReadM = 0;
    rst = 1'b0;
    do_access(1, 0, 0, 32'h84, 0, st, d);
    checks++; if (st !== 5 || d !== 32'hC0DE_0001) begin
      errors++; $display("FAIL midfill_remiss: got %h/%0d want c0de0001/5", d, st);
    end
    do_access(1, 0, 0, 32'h40, 0, st, d);
    checks++; if (st !== 5) begin errors++; $display("FAIL reset_invalidates: got %0d want 5", st); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[32'h40 >> 2] = 32'h11; mem[32'h44 >> 2] = 32'h22;
    mem[32'h48 >> 2] = 32'h33; mem[32'h4C >> 2] = 32'h44;
    mem[32'h1C0 >> 2] = 32'h8899_AABB; mem[32'h1C4 >> 2] = 32'h0102_0304;
    mem[32'h1C8 >> 2] = 32'h0506_0708; mem[32'h1CC >> 2] = 32'h090A_0B0C;
    for (int i = 0; i < 4; i++) mem[(32'h80 >> 2) + i] = 32'hC0DE_0000 + 32'(i);

    test_reset();
    test_fill();
    test_byte_load();
    test_byte_store();
    test_store_miss();
    test_store_priority();
    test_conflict();
    test_stray_ack();
    test_reset_mid_fill();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
